bcd_alu_apb: RTL and testbench
==============================

Name: bcd_alu_apb

Overview:
- Parametrised successor to the APB BCD summator, sitting as an APB slave on the peripheral bus.
- Adds or subtracts two packed-BCD operands of DATA_WIDTH/4 digits.
- Processes DIGITS_PER_CYCLE digits per clock under a small FSM and exposes busy/done/carry/error status.
- Guards result and argument registers with pslverr while a calculation is running.

Parameters:
- BASE_ADDR, 0, byte address of ARG1; registers follow at stride DATA_WIDTH/8.
- ADDR_WIDTH, 4, APB address width.
- DATA_WIDTH, 32, register width; multiple of 4. NDIG = DATA_WIDTH/4.
- DIGITS_PER_CYCLE, 1, digits processed per clock; must divide NDIG.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- aps_psel  in  1  APB select
- aps_penable  in  1  APB enable
- aps_pwrite  in  1  1 = write
- aps_paddr  in  ADDR_WIDTH  byte address
- aps_pwdata  in  DATA_WIDTH  write data
- aps_prdata  out  DATA_WIDTH  read data
- aps_pready  out  1  transfer complete
- aps_pslverr  out  1  transfer error

Behaviour:
- Register map, S = DATA_WIDTH/8:
  - ARG1 @BASE_ADDR (RW)
  - ARG2 @BASE_ADDR+S (RW)
  - RES @BASE_ADDR+2S (RO)
  - CTRL/STATUS @BASE_ADDR+3S
  - CTRL write bits: [0] start, [1] mode (0 add, 1 sub), [2] carry_in/borrow_in.
  - STATUS read bits: [0] carry/borrow out, [1] busy, [2] bad-digit error, [3] done; others 0.
- Reset values: aps_prdata=0, aps_pready=0, aps_pslverr=0; ARG1/ARG2/RES/STATUS=0; FSM=IDLE.
- Reset is asynchronous; asserted mid-calculation it aborts and clears everything.
- APB protocol:
  - Zero wait state. aps_pready = psel & penable & address-hit, combinational.
  - Address hit means one of the four mapped addresses.
  - Unmapped address or psel low: no pready, no pslverr, no state change, prdata=0.
  - Writes and read data take effect in the ACCESS cycle.
  - pslverr is valid only with pready.
- Error responses (pslverr=1, prdata=0, write discarded):
  - Read of RES while busy.
  - Write of ARG1/ARG2 while busy.
  - Write of CTRL with start=1 while busy.
- STATUS is always readable without error.
- Writing CTRL with start=0 is a no-op with pready=1 and pslverr=0.
- Writing ARG1 or ARG2 while IDLE clears done.
- FSM states: IDLE, CHECK, CALC.
  - IDLE → CHECK on an accepted start. Latch mode/cin; set busy=1, done=0, err=0.
  - CHECK (1 cycle): if any nibble of ARG1 or ARG2 is >9, set RES=0, carry=0, err=1, done=1, busy=0 and return to IDLE. Otherwise clear digit counter and go to CALC.
  - CALC: each cycle processes DIGITS_PER_CYCLE digits from LSD upward, writes the RES nibbles, and propagates carry in a register.
  - After NDIG/DIGITS_PER_CYCLE cycles: carry flag = final carry (add) or borrow (sub); done=1, busy=0; go to IDLE.
  - Total latency: 1 + NDIG/DIGITS_PER_CYCLE cycles after the start ACCESS cycle.
- Arithmetic:
  - Add: RES = (A + B + cin) mod 10^NDIG; carry = overflow.
  - Sub: each B digit is replaced by 9-b, chain carry-in = ~bin, borrow = ~final carry.
  - Sub result: RES = (A - B - bin) mod 10^NDIG (ten's complement on underflow).
- Per-digit adder: s = a+b+c; if s>9 then s-=10 and cout=1.
- RES holds its last value until the next calculation writes it.

Decomposition:
- Package bcd_alu_pkg holds:
  - register offset indices (ARG1=0, ARG2=1, RES=2, CTRL=3);
  - CTRL/STATUS bit positions;
  - FSM state enum {IDLE, CHECK, CALC};
  - function is_bcd(nibble).
- Sub-module bcd_digit_adder: combinational, inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout. Chained DIGITS_PER_CYCLE times in a generate loop.

Test Plan:
- Reset asserted, then released → STATUS=0, RES=0. Access to address BASE+4S and transfer with psel=0 → pready never 1, ARG1 unchanged.
- ARG1=0x00000025, ARG2=0x00000030, CTRL=0x1 → busy for 9 cycles (5 with DIGITS_PER_CYCLE=2), then RES=0x00000055, STATUS=0x8.
- ARG1=0x99999999, ARG2=0x00000001, CTRL=0x1 → RES=0x00000000, STATUS=0x9. Same operands with CTRL=0x5 → RES=0x00000001, STATUS=0x9.
- Sub: ARG1=0x00000030, ARG2=0x00000045, CTRL=0x3 → RES=0x99999985, STATUS=0x9. Then ARG1=0x45, ARG2=0x30 → RES=0x00000015, STATUS=0x8.
- Start, then immediately read RES → pslverr=1, prdata=0. Write ARG1=0x1234 while busy → pslverr=1, ARG1 unchanged. Read STATUS → busy=1, pslverr=0.
- ARG1=0x0000001A, CTRL=0x1 → after 2 cycles STATUS=0xC, RES=0. Reset asserted mid-CALC → STATUS=0, RES=0.

Source files
------------

// File: rtl/bcd_alu_pkg.sv
// Shared definitions for the APB BCD add/subtract unit: register map indices,
// control/status bit positions, FSM states and a digit validity helper.
package bcd_alu_pkg;

  localparam logic [1:0] REG_ARG1 = 2'd0;
  localparam logic [1:0] REG_ARG2 = 2'd1;
  localparam logic [1:0] REG_RES  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_MODE  = 1;
  localparam int CTRL_CIN   = 2;

  localparam int STAT_CARRY = 0;
  localparam int STAT_BUSY  = 1;
  localparam int STAT_ERR   = 2;
  localparam int STAT_DONE  = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, CALC = 2'd2} state_e;

  function automatic logic is_bcd(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_alu_apb_digit_adder.sv
// One packed-BCD digit adder stage; the top chains several per clock.
module bcd_digit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw_s;

  // Binary sum then decimal correction
  always_comb begin
    raw_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (raw_s > 5'd9) begin
      sum  = 4'(raw_s - 5'd10);
      cout = 1'b1;
    end else begin
      sum  = raw_s[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_alu_apb.sv
// APB slave that adds or subtracts two packed-BCD operands, DIGITS_PER_CYCLE
// digits per clock, with busy/done/carry/error status and busy guarding.
module bcd_alu_apb
  import bcd_alu_pkg::*;
#(
  parameter int BASE_ADDR        = 0,
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  aps_psel,
  input  logic                  aps_penable,
  input  logic                  aps_pwrite,
  input  logic [ADDR_WIDTH-1:0] aps_paddr,
  input  logic [DATA_WIDTH-1:0] aps_pwdata,
  output logic [DATA_WIDTH-1:0] aps_prdata,
  output logic                  aps_pready,
  output logic                  aps_pslverr
);

  localparam int NDIG  = DATA_WIDTH / 4;
  localparam int NSTEP = NDIG / DIGITS_PER_CYCLE;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int S     = DATA_WIDTH / 8;
  localparam int DPC   = DIGITS_PER_CYCLE;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] arg1_q, arg1_d, arg2_q, arg2_d, res_q, res_d;
  logic                  carry_q, carry_d, err_q, err_d, done_q, done_d;
  logic                  mode_q, mode_d, cin_q, cin_d, chain_q, chain_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  hit_s, access_s, busy_s, start_s, slverr_s, bad_s;
  logic [1:0]            idx_s;
  logic [DATA_WIDTH-1:0] status_s, rdata_s;
  logic [3:0]            da_s [DPC];
  logic [3:0]            db_s [DPC];
  logic [3:0]            sum_s [DPC];
  logic                  c_s [DPC+1];

  // Address decode onto the four mapped registers
  always_comb begin
    hit_s = 1'b0;
    idx_s = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (aps_paddr == ADDR_WIDTH'(BASE_ADDR + k * S)) begin
        hit_s = 1'b1;
        idx_s = 2'(k);
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign access_s = aps_psel & aps_penable & hit_s;
  assign busy_s   = (state_q != IDLE);
  assign start_s  = access_s & aps_pwrite & (idx_s == REG_CTRL) & aps_pwdata[CTRL_START];
  assign slverr_s = access_s & busy_s &
                    ((!aps_pwrite && idx_s == REG_RES) ||
                     (aps_pwrite && (idx_s == REG_ARG1 || idx_s == REG_ARG2)) ||
                     start_s);

  // Status word and read mux; erroring reads return zero
  always_comb begin
    status_s             = '0;
    status_s[STAT_CARRY] = carry_q;
    status_s[STAT_BUSY]  = busy_s;
    status_s[STAT_ERR]   = err_q;
    status_s[STAT_DONE]  = done_q;
    rdata_s              = '0;
    if (access_s && !aps_pwrite && !slverr_s) begin
      case (idx_s)
        REG_ARG1: rdata_s = arg1_q;
        REG_ARG2: rdata_s = arg2_q;
        REG_RES:  rdata_s = res_q;
        REG_CTRL: rdata_s = status_s;
        default:  rdata_s = '0;
      endcase
    end else begin
      rdata_s = '0;
    end
  end

  assign aps_prdata  = rdata_s;
  assign aps_pready  = access_s;
  assign aps_pslverr = slverr_s;

  // Operand validity scan and digit window for the current step
  always_comb begin
    bad_s = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (!is_bcd(arg1_q[i*4 +: 4]) || !is_bcd(arg2_q[i*4 +: 4])) begin
        bad_s = 1'b1;
      end else begin
        bad_s = bad_s;
      end
    end
    for (int i = 0; i < DPC; i++) begin
      da_s[i] = arg1_q[(int'(cnt_q) * DPC + i) * 4 +: 4];
      if (mode_q) begin
        db_s[i] = 4'd9 - arg2_q[(int'(cnt_q) * DPC + i) * 4 +: 4];
      end else begin
        db_s[i] = arg2_q[(int'(cnt_q) * DPC + i) * 4 +: 4];
      end
    end
  end

  assign c_s[0] = chain_q;

  for (genvar g = 0; g < DPC; g++) begin : g_dig
    bcd_digit_adder u_add (
      .a    (da_s[g]),
      .b    (db_s[g]),
      .cin  (c_s[g]),
      .sum  (sum_s[g]),
      .cout (c_s[g+1])
    );
  end

  // Register writes and calculation sequencing
  always_comb begin
    state_d = state_q;
    arg1_d  = arg1_q;
    arg2_d  = arg2_q;
    res_d   = res_q;
    carry_d = carry_q;
    err_d   = err_q;
    done_d  = done_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    chain_d = chain_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (access_s && aps_pwrite && idx_s == REG_ARG1) begin
          arg1_d = aps_pwdata;
          done_d = 1'b0;
        end else if (access_s && aps_pwrite && idx_s == REG_ARG2) begin
          arg2_d = aps_pwdata;
          done_d = 1'b0;
        end else if (start_s) begin
          mode_d  = aps_pwdata[CTRL_MODE];
          cin_d   = aps_pwdata[CTRL_CIN];
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (bad_s) begin
          res_d   = '0;
          carry_d = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          // Subtraction runs as A + nines-complement(B) with inverted borrow
          chain_d = mode_q ? ~cin_q : cin_q;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < DPC; i++) begin
          res_d[(int'(cnt_q) * DPC + i) * 4 +: 4] = sum_s[i];
        end
        chain_d = c_s[DPC];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NSTEP - 1)) begin
          carry_d = mode_q ? ~c_s[DPC] : c_s[DPC];
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = CALC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      arg1_q  <= '0;
      arg2_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      chain_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      arg1_q  <= arg1_d;
      arg2_q  <= arg2_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bcd_alu_apb.sv
// Self-checking bench for bcd_alu_apb: directed vector table, protocol corner
// sequences and randomized operations against a decimal-arithmetic model.
module tb_bcd_alu_apb;

  localparam int DPC  = 1;
  localparam int NDIG = 8;
  localparam int LAT  = 1 + NDIG / DPC;
  localparam logic [3:0] A_ARG1 = 4'h0;
  localparam logic [3:0] A_ARG2 = 4'h4;
  localparam logic [3:0] A_RES  = 4'h8;
  localparam logic [3:0] A_CS   = 4'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]  paddr = 4'h0;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ctrl;
    logic [31:0] res;
    logic [31:0] st;
  } vec_t;
  vec_t vecs [8];

  bcd_alu_apb #(.BASE_ADDR(0), .ADDR_WIDTH(4), .DATA_WIDTH(32), .DIGITS_PER_CYCLE(DPC)) dut (
    .clk(clk), .reset(reset), .aps_psel(psel), .aps_penable(penable), .aps_pwrite(pwrite),
    .aps_paddr(paddr), .aps_pwdata(pwdata), .aps_prdata(prdata), .aps_pready(pready),
    .aps_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic apb(input logic sel, input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic rdy, output logic err);
    @(negedge clk);
    psel = sel; pwrite = wr; paddr = addr; pwdata = wd; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rd = prdata; rdy = pready; err = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr_ok(input logic [3:0] addr, input logic [31:0] d);
    logic [31:0] r; logic y, e;
    apb(1'b1, 1'b1, addr, d, r, y, e);
    chk("wr_resp", {30'd0, y, e}, 32'h2);
  endtask

  task automatic rd_ok(input logic [3:0] addr, output logic [31:0] d);
    logic y, e;
    apb(1'b1, 1'b0, addr, 32'h0, d, y, e);
    chk("rd_resp", {30'd0, y, e}, 32'h2);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int n = 0;
    do begin
      rd_ok(A_CS, s);
      n++;
    end while (s[1] && n < 40);
    chk("idle_timeout", {31'd0, s[1]}, 32'h0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        output logic [31:0] res, output logic [31:0] st);
    wr_ok(A_ARG1, a);
    wr_ok(A_ARG2, b);
    wr_ok(A_CS, c);
    wait_idle();
    rd_ok(A_RES, res);
    rd_ok(A_CS, st);
  endtask

  function automatic longint bcd2int(input logic [31:0] x);
    longint v = 0;
    for (int i = NDIG - 1; i >= 0; i--) v = v * 10 + longint'(x[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [31:0] int2bcd(input longint v);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < NDIG; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                output logic [31:0] res, output logic [31:0] st);
    longint m = 100000000;
    longint r;
    logic ok = 1'b1;
    for (int i = 0; i < NDIG; i++) if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) ok = 1'b0;
    if (!ok) begin
      res = 32'h0; st = 32'hC;
    end else if (!c[1]) begin
      r = bcd2int(a) + bcd2int(b) + longint'(c[2]);
      res = int2bcd(r % m); st = (r >= m) ? 32'h9 : 32'h8;
    end else begin
      r = bcd2int(a) - bcd2int(b) - longint'(c[2]);
      res = int2bcd((r < 0) ? r + m : r); st = (r < 0) ? 32'h9 : 32'h8;
    end
  endfunction

  function automatic logic [31:0] rand_bcd();
    logic [31:0] r;
    for (int i = 0; i < NDIG; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 9) == 0) r[$urandom_range(0, NDIG - 1) * 4 +: 4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  initial begin
    logic [31:0] r, s, er, es;
    logic y, e;

    vecs[0] = '{32'h00000025, 32'h00000030, 32'h1, 32'h00000055, 32'h8};
    vecs[1] = '{32'h99999999, 32'h00000001, 32'h1, 32'h00000000, 32'h9};
    vecs[2] = '{32'h99999999, 32'h00000001, 32'h5, 32'h00000001, 32'h9};
    vecs[3] = '{32'h00000030, 32'h00000045, 32'h3, 32'h99999985, 32'h9};
    vecs[4] = '{32'h00000045, 32'h00000030, 32'h3, 32'h00000015, 32'h8};
    vecs[5] = '{32'h00000100, 32'h00000001, 32'h7, 32'h00000098, 32'h8};
    vecs[6] = '{32'h12345678, 32'h87654321, 32'h1, 32'h99999999, 32'h8};
    vecs[7] = '{32'h0000001A, 32'h00000030, 32'h1, 32'h00000000, 32'hC};

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    chk("rst_outputs", {prdata[29:0], pready, pslverr}, 32'h0);
    rd_ok(A_CS, r);  chk("rst_status", r, 32'h0);
    rd_ok(A_RES, r); chk("rst_res", r, 32'h0);
    rd_ok(A_ARG1, r); chk("rst_arg1", r, 32'h0);

    // Unmapped address and deselected transfer leave state alone
    wr_ok(A_ARG1, 32'h00000011);
    apb(1'b1, 1'b1, 4'h2, 32'h00000077, r, y, e);
    chk("unmapped_resp", {r[29:0], y, e}, 32'h0);
    apb(1'b0, 1'b1, A_ARG1, 32'h00000077, r, y, e);
    chk("nosel_resp", {r[29:0], y, e}, 32'h0);
    rd_ok(A_ARG1, r); chk("arg1_kept", r, 32'h00000011);

    // Exact latency: still busy one cycle before completion, done on time
    wr_ok(A_ARG1, 32'h00000025);
    wr_ok(A_ARG2, 32'h00000030);
    wr_ok(A_CS, 32'h1);
    repeat (LAT - 2) @(posedge clk);
    rd_ok(A_CS, r); chk("lat_busy", r, 32'h2);
    wait_idle();
    wr_ok(A_CS, 32'h1);
    repeat (LAT - 1) @(posedge clk);
    rd_ok(A_CS, r); chk("lat_done", r, 32'h8);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ctrl, r, s);
      chk($sformatf("vec%0d_res", i), r, vecs[i].res);
      chk($sformatf("vec%0d_st", i), s, vecs[i].st);
    end

    // Writing an argument while idle clears done only
    wr_ok(A_ARG1, 32'h00000045);
    rd_ok(A_CS, r); chk("done_clear", r, 32'h4);

    // Busy guarding
    wr_ok(A_ARG2, 32'h00000030);
    wr_ok(A_CS, 32'h1);
    apb(1'b1, 1'b0, A_RES, 32'h0, r, y, e);
    chk("busy_res_rd", {r[29:0], y, e}, 32'h3);
    apb(1'b1, 1'b1, A_ARG1, 32'h00001234, r, y, e);
    chk("busy_arg_wr", {30'd0, y, e}, 32'h3);
    apb(1'b1, 1'b0, A_CS, 32'h0, r, y, e);
    chk("busy_status", {r[29:0], y, e}, 32'hA);
    apb(1'b1, 1'b1, A_CS, 32'h1, r, y, e);
    chk("busy_restart", {30'd0, y, e}, 32'h3);
    apb(1'b1, 1'b1, A_CS, 32'h0, r, y, e);
    chk("busy_ctrl_nop", {30'd0, y, e}, 32'h2);
    wait_idle();
    rd_ok(A_ARG1, r); chk("busy_arg1_kept", r, 32'h00000045);
    rd_ok(A_RES, r);  chk("busy_res", r, 32'h00000075);
    wr_ok(A_CS, 32'h0);
    rd_ok(A_CS, r);  chk("ctrl_nop_idle", r, 32'h8);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b, c;
      a = rand_bcd();
      b = rand_bcd();
      c = {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
      model(a, b, c, er, es);
      run_op(a, b, c, r, s);
      chk($sformatf("rnd%0d_res", i), r, er);
      chk($sformatf("rnd%0d_st", i), s, es);
    end

    // Asynchronous reset in the middle of a calculation
    wr_ok(A_ARG1, 32'h11111111);
    wr_ok(A_ARG2, 32'h22222222);
    wr_ok(A_CS, 32'h1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #12 reset = 1'b0;
    rd_ok(A_CS, r);   chk("midrst_status", r, 32'h0);
    rd_ok(A_RES, r);  chk("midrst_res", r, 32'h0);
    rd_ok(A_ARG1, r); chk("midrst_arg1", r, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
